// File: rtl/spi_master_cs.sv
// SPI master with chip-select held across up to MAX_BYTES_PER_CS bytes.
// Byte-at-a-time handshake on the TX side; CS_n released for a guard gap afterwards.
module spi_master_cs #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int MAX_BYTES_PER_CS  = 2,
    parameter int CS_INACTIVE_CLKS  = 1,
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic [CW-1:0] i_TX_Count,
    input  logic [7:0]    i_TX_Byte,
    input  logic          i_TX_DV,
    output logic          o_TX_Ready,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,
    output logic          o_SPI_Clk,
    input  logic          i_SPI_MISO,
    output logic          o_SPI_MOSI,
    output logic          o_SPI_CS_n
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    localparam int            HW        = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);

    localparam int            GW       = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = (CS_INACTIVE_CLKS > 1) ? GW'(CS_INACTIVE_CLKS - 1) : '0;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES_PER_CS);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WAIT_BYTE,
        CS_GAP
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [HW-1:0] clk_cnt;
    logic [4:0]    edge_cnt;
    logic [7:0]    tx_byte;
    logic [2:0]    tx_idx;
    logic [7:0]    rx_shift;
    logic [CW-1:0] bytes_left;
    logic [CW-1:0] adj_count;
    logic [GW-1:0] gap_cnt;
    logic          spi_clk;
    logic          mosi;
    logic          tx_ready;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic [CW-1:0] rx_count;

    logic          byte_done;
    logic          half_tick;
    logic          gap_done;
    logic          leading;
    logic          sample_edge;
    logic          drive_edge;

    assign byte_done   = (state == XFER) && (edge_cnt == 5'd16);
    assign half_tick   = (clk_cnt == HALF_LAST);
    assign gap_done    = (state == CS_GAP) && (gap_cnt == GAP_LAST);
    // Edge parity is taken from the count before this edge: even count => leading edge.
    assign leading     = ~edge_cnt[0];
    assign sample_edge = leading ^ CPHA;
    // With CPHA=0 bit 7 is pre-driven, so the final trailing edge has nothing left to shift out.
    assign drive_edge  = ~sample_edge && !(~CPHA && (edge_cnt == 5'd15));

    always_comb begin
        adj_count = i_TX_Count;
        if (i_TX_Count == '0) begin
            adj_count = CW'(1);
        end else if (i_TX_Count > MAX_CNT) begin
            adj_count = MAX_CNT;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (i_TX_DV) next_state = XFER;
            XFER:      if (byte_done) next_state = (bytes_left > CW'(1)) ? WAIT_BYTE : CS_GAP;
            WAIT_BYTE: if (i_TX_DV) next_state = XFER;
            CS_GAP:    if (gap_done) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            clk_cnt    <= '0;
            edge_cnt   <= '0;
            tx_byte    <= '0;
            tx_idx     <= '0;
            rx_shift   <= '0;
            bytes_left <= '0;
            gap_cnt    <= '0;
            spi_clk    <= CPOL;
            mosi       <= 1'b0;
            tx_ready   <= 1'b0;
            rx_dv      <= 1'b0;
            rx_byte    <= '0;
            rx_count   <= '0;
        end else begin
            rx_dv    <= 1'b0;
            tx_ready <= (next_state == IDLE) || (next_state == WAIT_BYTE);
            if (rx_dv) begin
                rx_count <= rx_count + CW'(1);
            end
            case (state)
                IDLE, WAIT_BYTE: begin
                    if (i_TX_DV) begin
                        tx_byte  <= i_TX_Byte;
                        mosi     <= i_TX_Byte[7];
                        tx_idx   <= CPHA ? 3'd7 : 3'd6;
                        clk_cnt  <= '0;
                        edge_cnt <= '0;
                        spi_clk  <= CPOL;
                        if (state == IDLE) begin
                            bytes_left <= adj_count;
                        end
                    end
                end
                XFER: begin
                    if (byte_done) begin
                        rx_dv      <= 1'b1;
                        rx_byte    <= rx_shift;
                        bytes_left <= bytes_left - CW'(1);
                        gap_cnt    <= '0;
                    end else if (half_tick) begin
                        clk_cnt  <= '0;
                        edge_cnt <= edge_cnt + 5'd1;
                        spi_clk  <= ~spi_clk;
                        if (sample_edge) begin
                            rx_shift <= {rx_shift[6:0], i_SPI_MISO};
                        end
                        if (drive_edge) begin
                            mosi   <= tx_byte[tx_idx];
                            tx_idx <= tx_idx - 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + HW'(1);
                    end
                end
                CS_GAP: begin
                    if (gap_done) begin
                        gap_cnt  <= '0;
                        rx_count <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_SPI_CS_n = (state == IDLE) || (state == CS_GAP);
    assign o_SPI_Clk  = spi_clk;
    assign o_SPI_MOSI = mosi;
    assign o_TX_Ready = tx_ready;
    assign o_RX_DV    = rx_dv;
    assign o_RX_Byte  = rx_byte;
    assign o_RX_Count = rx_count;

endmodule

// File: doc/spi_master_cs.md
SPI_MASTER_CS -- requirements
Module: spi_master_cs

Interface
REQ-001 SHALL have parameter SPI_MODE, default 0, the SPI mode 0-3: CPOL = mode 2 or 3, CPHA = mode 1 or 3.
REQ-002 SHALL have parameter CLKS_PER_HALF_BIT, default 2, the number of i_Clk cycles per SPI clock half-period; legal values are 2 or more.
REQ-003 SHALL have parameter MAX_BYTES_PER_CS, default 2, the maximum number of bytes per chip-select assertion.
REQ-004 SHALL have parameter CS_INACTIVE_CLKS, default 1, the minimum number of i_Clk cycles CS_n is held high between transactions.
REQ-005 SHALL have these ports; CW = $clog2(MAX_BYTES_PER_CS+1):
- i_Clk  in  1  system clock; the only clock.
- i_Rst  in  1  reset; asynchronous, active-high.
- i_TX_Count  in  CW  number of bytes in the transaction; sampled with the first i_TX_DV only.
- i_TX_Byte  in  8  byte to send on MOSI.
- i_TX_DV  in  1  one-cycle strobe that registers i_TX_Byte.
- o_TX_Ready  out  1  high when a new byte is accepted.
- o_RX_Count  out  CW  index of the received byte within the transaction, starting at 0.
- o_RX_DV  out  1  one-cycle pulse: o_RX_Byte is valid.
- o_RX_Byte  out  8  byte received on MISO.
- o_SPI_Clk  out  1  SPI clock.
- i_SPI_MISO  in  1  serial data in.
- o_SPI_MOSI  out  1  serial data out.
- o_SPI_CS_n  out  1  chip select, active low.

Function
REQ-006 SHALL implement the FSM states IDLE, XFER, WAIT_BYTE and CS_GAP.
REQ-007 In IDLE, o_TX_Ready SHALL be 1; i_TX_DV SHALL latch i_TX_Byte and the count, and the next state SHALL be XFER.
REQ-008 The latched count SHALL be adjusted on capture: a count of 0 becomes 1, and a count above MAX_BYTES_PER_CS becomes MAX_BYTES_PER_CS.
REQ-009 Entering XFER from IDLE, o_SPI_CS_n SHALL go 0 and o_SPI_MOSI SHALL show TX bit 7 in the cycle after the accepted i_TX_DV.
REQ-010 Per byte, XFER SHALL generate exactly 16 o_SPI_Clk edges, each CLKS_PER_HALF_BIT cycles apart.
REQ-011 The first of those edges SHALL occur CLKS_PER_HALF_BIT cycles after XFER entry; o_SPI_Clk idles at CPOL.
REQ-012 Bits SHALL be sent and received MSB first.
REQ-013 When CPHA=0: MOSI SHALL change on trailing edges (bit 7 pre-driven), and MISO SHALL be sampled on leading edges.
REQ-014 When CPHA=1: MOSI SHALL change on leading edges, and MISO SHALL be sampled on trailing edges.
REQ-015 o_RX_DV SHALL pulse for exactly 1 cycle, one cycle after the 16th edge, together with o_RX_Byte and o_RX_Count.
REQ-016 In the same cycle as that o_RX_DV pulse, the FSM SHALL go to WAIT_BYTE if bytes remain, else to CS_GAP.
REQ-017 In WAIT_BYTE, o_SPI_CS_n SHALL stay 0, o_SPI_Clk SHALL stay at CPOL and o_TX_Ready SHALL be 1.
REQ-018 In WAIT_BYTE, i_TX_DV SHALL start the next byte with the same timing as REQ-009 to REQ-011; the wait time is unbounded.
REQ-019 In CS_GAP, o_SPI_CS_n SHALL be 1 and o_TX_Ready 0 for CS_INACTIVE_CLKS cycles; the FSM SHALL then return to IDLE and o_RX_Count SHALL clear to 0.
REQ-020 i_TX_DV SHALL be ignored in XFER and CS_GAP.
REQ-021 i_TX_Count SHALL be ignored in WAIT_BYTE.
REQ-022 o_TX_Ready SHALL fall in the cycle after an accepted i_TX_DV.
REQ-023 o_RX_Count SHALL increment modulo 2^CW after each o_RX_DV.
REQ-024 One byte SHALL take 16*CLKS_PER_HALF_BIT+1 cycles from i_TX_DV to o_RX_DV.

Reset
REQ-025 While i_Rst=1, regardless of state: FSM=IDLE, o_SPI_CS_n=1, o_SPI_Clk=CPOL, o_SPI_MOSI=0, o_TX_Ready=0, o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0, internal counters=0.
REQ-026 o_TX_Ready SHALL rise on the first i_Clk edge after i_Rst falls.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer immediately, with no o_RX_DV pulse and CS_n=1.

Verification
REQ-028 Mode 0, CLKS_PER_HALF_BIT=2, count=1, TX=0xA5, MISO looped back to MOSI -> 16 edges 2 cycles apart, o_RX_DV 33 cycles after i_TX_DV, o_RX_Byte=0xA5, o_RX_Count=0.
REQ-029 Mode 3, count=2, TX=0x3C then 0xC3 sent 5 cycles after the first o_RX_DV, loopback -> CS_n low throughout, o_SPI_Clk held at 1 in WAIT_BYTE, RX 0x3C (count 0) then 0xC3 (count 1), then CS_n high for CS_INACTIVE_CLKS.
REQ-030 Modes 1 and 2, slave model driving 0x5A -> MISO sampled on the correct edge, o_RX_Byte=0x5A.
REQ-031 i_TX_DV pulsed during XFER and during CS_GAP -> ignored, no extra bytes sent.
REQ-032 count=0, and count=MAX+1 -> exactly 1 byte and exactly MAX bytes transferred respectively.
REQ-033 i_Rst asserted at edge 7 of a byte -> CS_n=1, o_SPI_Clk=CPOL, no o_RX_DV; after release, a 0x81 transfer completes correctly.
